rom_rd_arbiter: RTL
===================

ROM_RD_ARBITER -- requirements
Module: rom_rd_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: read data width.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 ACLK  in  1  single clock; all logic on rising edge.
REQ-004 ARESETn  in  1  reset, synchronous, active-low.
REQ-005 Mx_ARID/ARAddr/ARLen/ARSize/ARBurst/ARValid  in  4/ADDR_W/4/3/2/1  master x AR channel (x = 0, 1).
REQ-006 Mx_ARReady  out  1  master x AR accept.
REQ-007 Mx_RID/RData/RResp/RLast/RValid  out  4/DATA_W/2/1/1  master x R channel.
REQ-008 Mx_RReady  in  1  master x R accept.
REQ-009 S_ARID/ARAddr/ARLen/ARSize/ARBurst/ARValid  out  8/ADDR_W/4/3/2/1  shared ROM slave AR channel.
REQ-010 S_ARReady  in  1  slave AR accept.
REQ-011 S_RID/RData/RResp/RLast/RValid  in  8/DATA_W/2/1/1  slave R channel.
REQ-012 S_RReady  out  1  slave R accept.
REQ-013 len_err  out  1  sticky flag: slave RLast position disagreed with granted ARLen.

Function
REQ-014 FSM states IDLE, ADDR, DATA; at most one outstanding burst.
REQ-015 IDLE: if any Mx_ARValid, grant one master; granted Mx_ARReady=1 combinationally that cycle, other Mx_ARReady=0; latch ID/Addr/Len/Size/Burst and grant index; next state ADDR.
REQ-016 Arbitration round-robin: both requesting -> grant master not granted last; single requester always granted; priority pointer resets to "M0 first".
REQ-017 ADDR: S_ARValid=1 with latched fields held stable; S_ARID = {3'b000, grant, latched ID}; on S_ARReady -> DATA. All Mx_ARReady=0.
REQ-018 ADDR latency: S_ARValid rises exactly one cycle after master handshake.
REQ-019 DATA: S_R* forwarded combinationally to granted master: Mx_RValid=S_RValid, Mx_RData/RResp/RLast=S_R*, Mx_RID=S_RID[3:0]; S_RReady=granted Mx_RReady; non-granted master RValid=0.
REQ-020 4-bit beat counter cleared on entry to DATA, incremented on each S_RValid&S_RReady, no wrap beyond ARLen in a legal burst.
REQ-021 DATA exit on S_RValid&S_RReady&S_RLast -> IDLE; new grant possible the cycle after.
REQ-022 len_err set if a completed beat has S_RLast=1 with count!=ARLen, or S_RLast=0 with count==ARLen; sticky until reset; on the latter, burst continues until slave RLast.
REQ-023 S_RID[4] mismatching grant: data still routed by latched grant (grant authoritative).
REQ-024 Outside DATA: S_RReady=0, all Mx_RValid=0; outside ADDR: S_ARValid=0.
REQ-025 Master ARValid dropping while not granted is legal; no state retained for it.
REQ-026 Mx_ARValid arriving during ADDR/DATA waits; no acceptance until IDLE.

Reset
REQ-027 ARESETn=0 at a clock edge: state IDLE, pointer M0-first, counter 0, len_err 0, latched fields 0.
REQ-028 During reset all outputs 0: Mx_ARReady, Mx_RValid, Mx_RLast, S_ARValid, S_RReady, len_err; data/ID outputs 0.
REQ-029 Reset mid-burst aborts burst; no further beats forwarded; slave must be reset concurrently.

Verification
REQ-030 M0 only, ARAddr=0x0000_0010, ARLen=3 -> M0_ARReady same cycle, S_ARValid next cycle with S_ARID=0x0?, 4 beats to M0, RLast on beat 4, back to IDLE.
REQ-031 M0 and M1 request same cycle after reset -> M0 granted (S_ARID[4]=0); after completion M1 granted (S_ARID[4]=1), then alternate if both keep requesting.
REQ-032 Slave holds S_ARReady=0 for 5 cycles -> S_ARValid and fields stable 5 cycles, no Mx_ARReady.
REQ-033 Master RReady toggles 1,0,1,0 on ARLen=1 burst -> S_RReady mirrors, exactly 2 beats, no data loss.
REQ-034 ARLen=3, slave RLast on beat 2 -> len_err=1, FSM returns IDLE, len_err stays 1 until reset.
REQ-035 ARESETn=0 during DATA beat 2 -> next cycle all outputs 0, state IDLE, next request granted to M0.

Source files
------------

// File: rtl/rom_rd_arbiter.sv
// Two-master round-robin arbiter in front of a single-outstanding AXI-style ROM read port.
// One burst at a time: grant in IDLE, present the address in ADDR, forward beats in DATA.
module rom_rd_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [3:0]        M0_ARID,
    input  logic [ADDR_W-1:0] M0_ARAddr,
    input  logic [3:0]        M0_ARLen,
    input  logic [2:0]        M0_ARSize,
    input  logic [1:0]        M0_ARBurst,
    input  logic              M0_ARValid,
    output logic              M0_ARReady,
    output logic [3:0]        M0_RID,
    output logic [DATA_W-1:0] M0_RData,
    output logic [1:0]        M0_RResp,
    output logic              M0_RLast,
    output logic              M0_RValid,
    input  logic              M0_RReady,
    input  logic [3:0]        M1_ARID,
    input  logic [ADDR_W-1:0] M1_ARAddr,
    input  logic [3:0]        M1_ARLen,
    input  logic [2:0]        M1_ARSize,
    input  logic [1:0]        M1_ARBurst,
    input  logic              M1_ARValid,
    output logic              M1_ARReady,
    output logic [3:0]        M1_RID,
    output logic [DATA_W-1:0] M1_RData,
    output logic [1:0]        M1_RResp,
    output logic              M1_RLast,
    output logic              M1_RValid,
    input  logic              M1_RReady,
    output logic [7:0]        S_ARID,
    output logic [ADDR_W-1:0] S_ARAddr,
    output logic [3:0]        S_ARLen,
    output logic [2:0]        S_ARSize,
    output logic [1:0]        S_ARBurst,
    output logic              S_ARValid,
    input  logic              S_ARReady,
    input  logic [7:0]        S_RID,
    input  logic [DATA_W-1:0] S_RData,
    input  logic [1:0]        S_RResp,
    input  logic              S_RLast,
    input  logic              S_RValid,
    output logic              S_RReady,
    output logic              len_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state_reg, state_next;
    logic              prio_reg;
    logic              grant_reg;
    logic [3:0]        id_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        len_reg;
    logic [2:0]        size_reg;
    logic [1:0]        burst_reg;
    logic [3:0]        beat_cnt_reg;
    logic              len_err_reg;

    logic [1:0]        ar_valid;
    logic [1:0]        ar_ready;
    logic [1:0]        r_ready;
    logic [1:0]        r_route;
    logic [3:0]        ar_id    [2];
    logic [ADDR_W-1:0] ar_addr  [2];
    logic [3:0]        ar_len   [2];
    logic [2:0]        ar_size  [2];
    logic [1:0]        ar_burst [2];
    logic              grant_sel;
    logic              in_addr;
    logic              in_data;
    logic              beat_hs;
    logic              unused_rid_hi;

    assign ar_valid    = {M1_ARValid, M0_ARValid};
    assign r_ready     = {M1_RReady, M0_RReady};
    assign ar_id[0]    = M0_ARID;
    assign ar_id[1]    = M1_ARID;
    assign ar_addr[0]  = M0_ARAddr;
    assign ar_addr[1]  = M1_ARAddr;
    assign ar_len[0]   = M0_ARLen;
    assign ar_len[1]   = M1_ARLen;
    assign ar_size[0]  = M0_ARSize;
    assign ar_size[1]  = M1_ARSize;
    assign ar_burst[0] = M0_ARBurst;
    assign ar_burst[1] = M1_ARBurst;

    // Returned ID's upper bits are not consulted: the latched grant decides routing.
    assign unused_rid_hi = ^S_RID[7:4];

    // prio_reg names the master that wins a tie.
    assign grant_sel = (&ar_valid) ? prio_reg : ar_valid[1];

    assign in_addr = ARESETn && (state_reg == ADDR);
    assign in_data = ARESETn && (state_reg == DATA);
    assign beat_hs = S_RValid && S_RReady;

    always_comb begin
        state_next = state_reg;
        ar_ready   = '0;
        case (state_reg)
            IDLE: begin
                if (|ar_valid) begin
                    ar_ready[grant_sel] = 1'b1;
                    state_next          = ADDR;
                end
            end
            ADDR:    if (S_ARReady) state_next = DATA;
            DATA:    if (beat_hs && S_RLast) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (!ARESETn) ar_ready = '0;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_reg    <= IDLE;
            prio_reg     <= 1'b0;
            grant_reg    <= 1'b0;
            id_reg       <= '0;
            addr_reg     <= '0;
            len_reg      <= '0;
            size_reg     <= '0;
            burst_reg    <= '0;
            beat_cnt_reg <= '0;
            len_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && (|ar_valid)) begin
                grant_reg <= grant_sel;
                prio_reg  <= ~grant_sel;
                id_reg    <= ar_id[grant_sel];
                addr_reg  <= ar_addr[grant_sel];
                len_reg   <= ar_len[grant_sel];
                size_reg  <= ar_size[grant_sel];
                burst_reg <= ar_burst[grant_sel];
            end
            if (state_reg == ADDR && S_ARReady) beat_cnt_reg <= '0;
            if (state_reg == DATA && beat_hs) begin
                beat_cnt_reg <= beat_cnt_reg + 4'd1;
                // A last flag on the wrong beat, or a missing one on the expected last beat.
                if (S_RLast != (beat_cnt_reg == len_reg)) len_err_reg <= 1'b1;
            end
        end
    end

    assign S_ARValid = in_addr;
    assign S_ARID    = in_addr ? {3'b000, grant_reg, id_reg} : '0;
    assign S_ARAddr  = in_addr ? addr_reg  : '0;
    assign S_ARLen   = in_addr ? len_reg   : '0;
    assign S_ARSize  = in_addr ? size_reg  : '0;
    assign S_ARBurst = in_addr ? burst_reg : '0;
    assign S_RReady  = in_data && r_ready[grant_reg];
    assign len_err   = ARESETn && len_err_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_route
            assign r_route[gi] = in_data && (grant_reg == 1'(gi));
        end
    endgenerate

    assign M0_ARReady = ar_ready[0];
    assign M1_ARReady = ar_ready[1];
    assign M0_RValid  = r_route[0] && S_RValid;
    assign M1_RValid  = r_route[1] && S_RValid;
    assign M0_RLast   = r_route[0] && S_RLast;
    assign M1_RLast   = r_route[1] && S_RLast;
    assign M0_RData   = r_route[0] ? S_RData : '0;
    assign M1_RData   = r_route[1] ? S_RData : '0;
    assign M0_RResp   = r_route[0] ? S_RResp : '0;
    assign M1_RResp   = r_route[1] ? S_RResp : '0;
    assign M0_RID     = r_route[0] ? S_RID[3:0] : '0;
    assign M1_RID     = r_route[1] ? S_RID[3:0] : '0;

endmodule
